range_sweep_arbiter: RTL and testbench

RANGE_SWEEP_ARBITER -- requirements
Module: range_sweep_arbiter

---
 rtl/range_sweep_arbiter.sv | 114 +++++++++++
 tb/tb_range_sweep_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/range_sweep_arbiter.sv
// range_sweep_arbiter: round-robin arbiter that grants one requester at a time
// and streams that requester's value range [start..end] as a beat sequence.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_i[NumReq]          per-requester sweep request (level)
//   start_val_i/end_val_i  packed per-requester bounds, slice k = [k*Bits +: Bits]
//   ready_i                downstream accepts the current beat
//   gnt_o                  one-hot owner of the active sweep
//   count_o                current sweep value
//   valid_o, last_o        beat valid / final beat of the sweep
//   done_o                 one-cycle completion pulse on the owner bit
//   busy_o                 high while a sweep is running or completing
module range_sweep_arbiter #(
  parameter int Bits   = 8,
  parameter int NumReq = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq*Bits-1:0]   start_val_i,
  input  logic [NumReq*Bits-1:0]   end_val_i,
  input  logic                     ready_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [Bits-1:0]          count_o,
  output logic                     valid_o,
  output logic                     last_o,
  output logic [NumReq-1:0]        done_o,
  output logic                     busy_o
);

  localparam int PtrW = $clog2(NumReq);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                       state, state_nxt;
  logic [PtrW-1:0]              ptr, owner, pick;
  logic                         found;
  logic [NumReq-1:0][Bits-1:0]  start_v, end_v;
  logic [Bits-1:0]              count, end_q;
  logic                         last;
  logic [NumReq-1:0]            onehot;

  for (genvar k = 0; k < NumReq; k++) begin : g_unpack
    assign start_v[k] = start_val_i[k*Bits +: Bits];
    assign end_v[k]   = end_val_i[k*Bits +: Bits];
  end

  // Round-robin pick: walk offsets from high to low so the smallest offset
  // from ptr (the first set index at/after ptr, wrapping) wins.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = ptr;
    idx   = 0;
    for (int i = NumReq-1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      if (req_i[idx]) begin
        found = 1'b1;
        pick  = PtrW'(idx);
      end
    end
  end

  // count never passes end_q, so stopping at >= also covers start > end
  // (single beat) and end = all-ones (no wrap).
  assign last   = (state == RUN) && (count >= end_q);
  assign onehot = NumReq'(1) << owner;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = RUN;
      RUN:     if (ready_i && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bounds are captured at grant so later req/bound changes are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr   <= '0;
      owner <= '0;
      count <= '0;
      end_q <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          owner <= pick;
          count <= start_v[pick];
          end_q <= end_v[pick];
        end
        RUN:  if (ready_i && !last) count <= count + 1'b1;
        DONE: ptr <= (owner == PtrW'(NumReq-1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  assign gnt_o   = (state == RUN)  ? onehot : '0;
  assign done_o  = (state == DONE) ? onehot : '0;
  assign valid_o = (state == RUN);
  assign last_o  = last;
  assign count_o = count;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_range_sweep_arbiter.sv
module tb_range_sweep_arbiter;
  localparam int Bits = 8;
  localparam int NumReq = 4;

  logic                    clk = 1'b0;
  logic                    rst_ni;
  logic [NumReq-1:0]       req_i;
  logic [NumReq*Bits-1:0]  start_val_i, end_val_i;
  logic                    ready_i;
  logic [NumReq-1:0]       gnt_o, done_o;
  logic [Bits-1:0]         count_o;
  logic                    valid_o, last_o, busy_o;

  range_sweep_arbiter #(.Bits(Bits), .NumReq(NumReq)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i),
    .start_val_i(start_val_i), .end_val_i(end_val_i), .ready_i(ready_i),
    .gnt_o(gnt_o), .count_o(count_o), .valid_o(valid_o), .last_o(last_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NumReq-1:0] gnt;
    logic [Bits-1:0]   cnt;
    logic              last;
  } beat_t;

  beat_t q[$];
  int total = 0;
  int bad = 0;
  int nxf = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [NumReq-1:0] g, input logic [Bits-1:0] c, input logic l);
    beat_t b;
    b.gnt = g; b.cnt = c; b.last = l;
    q.push_back(b);
  endtask

  task automatic set_rng(input int k, input logic [Bits-1:0] s, input logic [Bits-1:0] e);
    start_val_i[k*Bits +: Bits] = s;
    end_val_i[k*Bits +: Bits]   = e;
  endtask

  // One clock: retire the beat accepted at this edge, then compare whatever
  // beat the DUT presents against the head of the scoreboard.
  task automatic cyc();
    bit xf;
    xf = (valid_o === 1'b1) && (ready_i === 1'b1);
    @(posedge clk); #1;
    if (xf) begin
      nxf++;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (valid_o === 1'b1) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL extra_beat got count=%0h gnt=%0h exp=no beat", count_o, gnt_o);
      end
      if (q.size() != 0) begin
        chk("beat_count", count_o, q[0].cnt);
        chk("beat_last", last_o, q[0].last);
        chk("beat_gnt", gnt_o, q[0].gnt);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_last"}, last_o, 0);
    chk({tag, "_gnt"}, gnt_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; req_i = '0; ready_i = 1'b1;
    start_val_i = '0; end_val_i = '0;

    // reset state
    cyc(); cyc();
    chk_zero("reset");
    rst_ni = 1'b1;

    // single requester 3..6; req dropped after grant must not abort
    req_i = 4'b0001; set_rng(0, 8'd3, 8'd6);
    push(4'b0001, 8'd3, 1'b0); push(4'b0001, 8'd4, 1'b0);
    push(4'b0001, 8'd5, 1'b0); push(4'b0001, 8'd6, 1'b1);
    cyc();
    chk("t1_gnt", gnt_o, 4'b0001);
    req_i = '0; set_rng(0, 8'd0, 8'd0);
    cyc(); cyc(); cyc();
    cyc();
    chk("t1_done", done_o, 4'b0001);
    chk("t1_done_valid", valid_o, 0);
    chk("t1_done_gnt", gnt_o, 0);
    chk("t1_done_busy", busy_o, 1);
    cyc();
    chk("t1_idle_busy", busy_o, 0);
    chk("t1_idle_done", done_o, 0);

    // backpressure 10..12 on requester 1
    nxf = 0;
    req_i = 4'b0010; set_rng(1, 8'd10, 8'd12); ready_i = 1'b0;
    push(4'b0010, 8'd10, 1'b0); push(4'b0010, 8'd11, 1'b0); push(4'b0010, 8'd12, 1'b1);
    cyc();
    req_i = '0;
    chk("t2_first", count_o, 8'd10);
    cyc(); chk("t2_hold1", count_o, 8'd10);
    cyc(); chk("t2_hold2", count_o, 8'd10);
    ready_i = 1'b1;
    cyc(); cyc(); cyc();
    chk("t2_done", done_o, 4'b0010);
    chk("t2_xfers", nxf, 3);
    cyc();

    // round-robin from ptr=0 with req 0101 held
    rst_ni = 1'b0; cyc(); rst_ni = 1'b1;
    for (int k = 0; k < NumReq; k++) set_rng(k, 8'd7, 8'd7);
    req_i = 4'b0101;
    for (int i = 0; i < 4; i++) push((i % 2 == 0) ? 4'b0001 : 4'b0100, 8'd7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_gnt", gnt_o, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      cyc();
      chk("t3_done", done_o, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      chk("t3_done_valid", valid_o, 0);
      cyc();
      chk("t3_gap_valid", valid_o, 0);
      chk("t3_gap_busy", busy_o, 0);
    end
    req_i = '0;
    cyc();
    chk("t3_idle", busy_o, 0);

    // start > end: single beat 9
    req_i = 4'b0001; set_rng(0, 8'd9, 8'd4);
    push(4'b0001, 8'd9, 1'b1);
    cyc();
    req_i = '0;
    cyc();
    chk("t4a_done", done_o, 4'b0001);
    cyc();

    // end = all-ones: FE, FF, no wrap
    req_i = 4'b1000; set_rng(3, 8'hFE, 8'hFF);
    push(4'b1000, 8'hFE, 1'b0); push(4'b1000, 8'hFF, 1'b1);
    cyc();
    req_i = '0;
    cyc();
    cyc();
    chk("t4b_done", done_o, 4'b1000);
    chk("t4b_valid", valid_o, 0);
    cyc();
    chk("t4b_idle", busy_o, 0);

    // reset mid-sweep at count 5 of 0..9, req held through reset
    req_i = 4'b0010; set_rng(1, 8'd0, 8'd9);
    for (int v = 0; v <= 5; v++) push(4'b0010, v[Bits-1:0], 1'b0);
    cyc();
    req_i = 4'b0011;
    for (int v = 0; v < 5; v++) cyc();
    chk("t5_at5", count_o, 8'd5);
    rst_ni = 1'b0;
    cyc();
    chk_zero("t5_rst");
    cyc();
    chk_zero("t5_rst2");
    set_rng(0, 8'd2, 8'd2);
    push(4'b0001, 8'd2, 1'b1);
    rst_ni = 1'b1;
    cyc();
    chk("t5_gnt", gnt_o, 4'b0001);
    req_i = '0;
    cyc();
    chk("t5_done", done_o, 4'b0001);
    cyc();
    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
